nn_sequencer: RTL and testbench

Controller that sequences one inference on the combinational/multi-cycle `neural_net` core. It collects a stream of IEEE-754 single-precision features into a register bank and presents them to the core's X inputs. It then pulses start, waits for done and captures the outputs. It picks the winning intent with a floating-point argmax and returns it over a valid/ready handshake to the chatbot front end.

---
 rtl/nn_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_nn_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer.sv
// nn_sequencer: loads one feature frame, runs one neural_net inference, and returns the argmax.
// Optional build macro NN_WATCHDOG_EN adds a timeout on the WAIT state (err_timeout).
module nn_sequencer #(
    parameter int unsigned N_FEAT         = 16,
    parameter int unsigned N_OUT          = 2,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                     Clk,
    input  logic                                     Reset_n,
    input  logic                                     feat_valid,
    input  logic [DATA_W-1:0]                        feat_data,
    input  logic                                     feat_last,
    output logic                                     feat_ready,
    output logic [N_FEAT*DATA_W-1:0]                 nn_x,
    output logic                                     nn_start,
    input  logic                                     nn_done,
    input  logic [N_OUT*DATA_W-1:0]                  nn_o,
    output logic                                     res_valid,
    input  logic                                     res_ready,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] res_class,
    output logic [DATA_W-1:0]                        res_score,
    output logic                                     busy,
    output logic                                     err_frame,
    output logic                                     err_timeout
);

    localparam int unsigned IdxW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned ClsW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWait,
        StArgmax,
        StResult
    } state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [N_FEAT*DATA_W-1:0]  feat_q;
    logic [N_OUT*DATA_W-1:0]   obuf_q;
    logic [ClsW-1:0]           scan_q, scan_d;
    logic [ClsW-1:0]           best_idx_q, best_idx_d;
    logic [DATA_W-1:0]         best_val_q, best_val_d;
    logic                      err_frame_q, err_frame_d;
    logic                      wr_en;
    logic                      capture;
    logic                      last_slot;
    logic [DATA_W-1:0]         cand;
    logic                      cand_wins;

`ifdef NN_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0]            wd_q, wd_d;
    logic                      err_timeout_q, err_timeout_d;
`endif

    // Total-order float compare: true when a strictly beats b; +0 and -0 compare equal.
    function automatic logic fp_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-2:0] am;
        logic [DATA_W-2:0] bm;
        logic              gt;
        am = a[DATA_W-2:0];
        bm = b[DATA_W-2:0];
        if (am == '0 && bm == '0) begin
            gt = 1'b0;
        end else if (a[DATA_W-1] != b[DATA_W-1]) begin
            gt = b[DATA_W-1];
        end else if (!a[DATA_W-1]) begin
            gt = (am > bm);
        end else begin
            gt = (am < bm);
        end
        return gt;
    endfunction

    assign last_slot = (idx_q == IdxW'(N_FEAT - 1));
    assign cand      = obuf_q[scan_q*DATA_W +: DATA_W];
    assign cand_wins = fp_gt(cand, best_val_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        scan_d      = scan_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        err_frame_d = 1'b0;
        wr_en       = 1'b0;
        capture     = 1'b0;
`ifdef NN_WATCHDOG_EN
        wd_d          = wd_q;
        err_timeout_d = 1'b0;
`endif
        unique case (state_q)
            StLoad: begin
                if (feat_valid) begin
                    // A word is well framed only when feat_last marks exactly the final slot.
                    if (feat_last == last_slot) begin
                        wr_en = 1'b1;
                        if (last_slot) begin
                            idx_d   = '0;
                            state_d = StStart;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        err_frame_d = 1'b1;
                        idx_d       = '0;
                    end
                end
            end
            StStart: begin
`ifdef NN_WATCHDOG_EN
                wd_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (nn_done) begin
                    capture    = 1'b1;
                    best_idx_d = '0;
                    best_val_d = nn_o[DATA_W-1:0];
                    scan_d     = ClsW'(1);
                    state_d    = (N_OUT > 1) ? StArgmax : StResult;
                end
`ifdef NN_WATCHDOG_EN
                else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    idx_d         = '0;
                    state_d       = StLoad;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            StArgmax: begin
                if (cand_wins) begin
                    best_idx_d = scan_q;
                    best_val_d = cand;
                end
                scan_d = scan_q + 1'b1;
                if (scan_q == ClsW'(N_OUT - 1)) begin
                    state_d = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= StLoad;
            idx_q       <= '0;
            feat_q      <= '0;
            obuf_q      <= '0;
            scan_q      <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            scan_q      <= scan_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            err_frame_q <= err_frame_d;
            if (wr_en) begin
                feat_q[idx_q*DATA_W +: DATA_W] <= feat_data;
            end
            if (capture) begin
                obuf_q <= nn_o;
            end
        end
    end

`ifdef NN_WATCHDOG_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign feat_ready = (state_q == StLoad);
    assign busy       = (state_q != StLoad);
    assign nn_start   = (state_q == StStart);
    assign res_valid  = (state_q == StResult);
    assign nn_x       = feat_q;
    assign res_class  = best_idx_q;
    assign res_score  = best_val_q;
    assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed self-checking bench for nn_sequencer: framing, handshake, argmax ordering, reset.
module tb_nn_sequencer;

    localparam int N_FEAT = 16;
    localparam int N_OUT  = 2;
    localparam int DW     = 32;

    logic                   Clk = 1'b0;
    logic                   Reset_n;
    logic                   feat_valid;
    logic [DW-1:0]          feat_data;
    logic                   feat_last;
    logic                   feat_ready;
    logic [N_FEAT*DW-1:0]   nn_x;
    logic                   nn_start;
    logic                   nn_done;
    logic [N_OUT*DW-1:0]    nn_o;
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_class;
    logic [DW-1:0]          res_score;
    logic                   busy;
    logic                   err_frame;
    logic                   err_timeout;

    int checks   = 0;
    int failures = 0;

    nn_sequencer #(
        .N_FEAT        (N_FEAT),
        .N_OUT         (N_OUT),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .feat_ready (feat_ready),
        .nn_x       (nn_x),
        .nn_start   (nn_start),
        .nn_done    (nn_done),
        .nn_o       (nn_o),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_class  (res_class),
        .res_score  (res_score),
        .busy       (busy),
        .err_frame  (err_frame),
        .err_timeout(err_timeout)
    );

    always #5 Clk = ~Clk;

    // Inputs change on the falling edge; outputs are sampled there too, before changing inputs.
    task automatic send_frame(input int n, input int last_pos, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            feat_valid = 1'b1;
            feat_data  = base + 32'(i);
            feat_last  = (i == last_pos);
            @(negedge Clk);
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    // Called on the START cycle; returns on the first RESULT cycle.
    task automatic finish_inference(input logic [31:0] o1, input logic [31:0] o2, input int dly);
        repeat (dly) @(negedge Clk);
        nn_o    = {o2, o1};
        nn_done = 1'b1;
        @(negedge Clk);
        nn_done = 1'b0;
        @(negedge Clk);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(negedge Clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        checks++;
        if ({feat_ready, busy, nn_start, res_valid, err_frame, err_timeout} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {feat_ready, busy, nn_start, res_valid, err_frame, err_timeout});
        end
        checks++;
        if (nn_x !== '0) begin
            failures++;
            $display("FAIL reset_nn_x got=%h exp=0", nn_x);
        end
        checks++;
        if ({res_class, res_score} !== 33'd0) begin
            failures++;
            $display("FAIL reset_result got=%0d/%h exp=0/0", res_class, res_score);
        end
    endtask

    task automatic test_basic();
        logic [N_FEAT*DW-1:0] exp_x;
        for (int i = 0; i < N_FEAT; i++) exp_x[i*DW +: DW] = 32'h3F80_0000 + 32'(i);
        send_frame(N_FEAT, N_FEAT - 1, 32'h3F80_0000);
        checks++;
        if ({nn_start, busy, feat_ready} !== 3'b110) begin
            failures++;
            $display("FAIL basic_start got=%b exp=110", {nn_start, busy, feat_ready});
        end
        checks++;
        if (nn_x !== exp_x) begin
            failures++;
            $display("FAIL basic_nn_x got=%h exp=%h", nn_x, exp_x);
        end
        @(negedge Clk);
        checks++;
        if ({nn_start, busy} !== 2'b01) begin
            failures++;
            $display("FAIL basic_start_pulse got=%b exp=01", {nn_start, busy});
        end
        repeat (4) @(negedge Clk);
        nn_o    = {32'hC000_0000, 32'h3F80_0000};
        nn_done = 1'b1;
        @(negedge Clk);
        nn_done = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b exp=0", res_valid);
        end
        @(negedge Clk);
        checks++;
        if ({res_valid, res_class, res_score} !== {1'b1, 1'b0, 32'h3F80_0000}) begin
            failures++;
            $display("FAIL basic_result got=%b/%0d/%h exp=1/0/3f800000",
                     res_valid, res_class, res_score);
        end
        checks++;
        if (nn_x !== exp_x) begin
            failures++;
            $display("FAIL basic_nn_x_hold got=%h exp=%h", nn_x, exp_x);
        end
        accept_result();
        checks++;
        if ({res_valid, feat_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL basic_release got=%b exp=010", {res_valid, feat_ready, busy});
        end
    endtask

    task automatic test_compare();
        logic [31:0] o1 [6];
        logic [31:0] o2 [6];
        logic        ec [6];
        logic [31:0] es [6];
        o1 = '{32'hBF80_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000,
               32'hC000_0000};
        o2 = '{32'hC000_0000, 32'h3E00_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h8000_0000,
               32'h8000_0000};
        ec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        es = '{32'hBF80_0000, 32'h3E00_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h0000_0000,
               32'h8000_0000};
        for (int k = 0; k < 6; k++) begin
            send_frame(N_FEAT, N_FEAT - 1, 32'h0100_0000 * 32'(k));
            finish_inference(o1[k], o2[k], 2);
            checks++;
            if ({res_valid, res_class, res_score} !== {1'b1, ec[k], es[k]}) begin
                failures++;
                $display("FAIL compare_%0d got=%b/%0d/%h exp=1/%0d/%h",
                         k, res_valid, res_class, res_score, ec[k], es[k]);
            end
            accept_result();
        end
    endtask

    task automatic test_tie_hold();
        send_frame(N_FEAT, N_FEAT - 1, 32'h4000_0000);
        finish_inference(32'h8000_0000, 32'h0000_0000, 3);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({res_valid, feat_ready, res_class, res_score} !== {3'b100, 32'h8000_0000}) begin
                failures++;
                $display("FAIL tie_hold_c%0d got=%b%b/%0d/%h exp=10/0/80000000",
                         c, res_valid, feat_ready, res_class, res_score);
            end
            @(negedge Clk);
        end
        accept_result();
        checks++;
        if (feat_ready !== 1'b1) begin
            failures++;
            $display("FAIL tie_release got=%b exp=1", feat_ready);
        end
    endtask

    task automatic test_frame_error();
        logic [N_FEAT*DW-1:0] exp_x;
        send_frame(N_FEAT, N_FEAT - 1, 32'h1111_0000);
        finish_inference(32'h3F80_0000, 32'h3F00_0000, 1);
        accept_result();
        // feat_last on word 5: words 1..4 land, word 5 is dropped, slots 5..16 stay stale.
        send_frame(5, 4, 32'h2222_0000);
        for (int i = 0; i < N_FEAT; i++)
            exp_x[i*DW +: DW] = (i < 4) ? 32'h2222_0000 + 32'(i) : 32'h1111_0000 + 32'(i);
        checks++;
        if ({err_frame, nn_start, feat_ready} !== 3'b101) begin
            failures++;
            $display("FAIL ferr_early got=%b exp=101", {err_frame, nn_start, feat_ready});
        end
        checks++;
        if (nn_x !== exp_x) begin
            failures++;
            $display("FAIL ferr_early_nn_x got=%h exp=%h", nn_x, exp_x);
        end
        @(negedge Clk);
        checks++;
        if ({err_frame, nn_start} !== 2'b00) begin
            failures++;
            $display("FAIL ferr_pulse got=%b exp=00", {err_frame, nn_start});
        end
        // Missing feat_last on word 16: slot 16 keeps the old frame's value.
        send_frame(N_FEAT, 99, 32'h3333_0000);
        for (int i = 0; i < N_FEAT; i++)
            exp_x[i*DW +: DW] = (i < 15) ? 32'h3333_0000 + 32'(i) : 32'h1111_0000 + 32'(i);
        checks++;
        if ({err_frame, nn_start, busy} !== 3'b100) begin
            failures++;
            $display("FAIL ferr_late got=%b exp=100", {err_frame, nn_start, busy});
        end
        checks++;
        if (nn_x !== exp_x) begin
            failures++;
            $display("FAIL ferr_late_nn_x got=%h exp=%h", nn_x, exp_x);
        end
        send_frame(N_FEAT, N_FEAT - 1, 32'h4444_0000);
        for (int i = 0; i < N_FEAT; i++) exp_x[i*DW +: DW] = 32'h4444_0000 + 32'(i);
        checks++;
        if ({nn_start, err_frame} !== 2'b10 || nn_x !== exp_x) begin
            failures++;
            $display("FAIL ferr_recover got=%b/%h exp=10/%h", {nn_start, err_frame}, nn_x, exp_x);
        end
        finish_inference(32'h3E00_0000, 32'h3F00_0000, 4);
        checks++;
        if ({res_valid, res_class, res_score} !== {2'b11, 32'h3F00_0000}) begin
            failures++;
            $display("FAIL ferr_result got=%b/%0d/%h exp=1/1/3f000000",
                     res_valid, res_class, res_score);
        end
        accept_result();
    endtask

    task automatic test_back_to_back();
        send_frame(N_FEAT, N_FEAT - 1, 32'h5555_0000);
        // nn_done during START must be ignored.
        nn_o    = {32'h4040_0000, 32'h4000_0000};
        nn_done = 1'b1;
        @(negedge Clk);
        nn_done = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({res_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_start_done got=%b exp=01", {res_valid, busy});
        end
        nn_o    = {32'h4000_0000, 32'h3F80_0000};
        nn_done = 1'b1;
        @(negedge Clk);
        nn_done = 1'b0;
        @(negedge Clk);
        checks++;
        if ({res_valid, res_class, res_score} !== {2'b11, 32'h4000_0000}) begin
            failures++;
            $display("FAIL b2b_result got=%b/%0d/%h exp=1/1/40000000",
                     res_valid, res_class, res_score);
        end
        accept_result();
        send_frame(N_FEAT, N_FEAT - 1, 32'h6666_0000);
        checks++;
        if (nn_start !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got=%b exp=1", nn_start);
        end
        finish_inference(32'hC080_0000, 32'hC040_0000, 1);
        checks++;
        if ({res_valid, res_class, res_score} !== {2'b11, 32'hC040_0000}) begin
            failures++;
            $display("FAIL b2b_second got=%b/%0d/%h exp=1/1/c0400000",
                     res_valid, res_class, res_score);
        end
        accept_result();
    endtask

    task automatic test_reset_mid_wait();
        send_frame(N_FEAT, N_FEAT - 1, 32'h7777_0000);
        repeat (3) @(negedge Clk);
        checks++;
        if ({busy, feat_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rstw_waiting got=%b exp=10", {busy, feat_ready});
        end
`ifndef NN_WATCHDOG_EN
        begin
            logic seen_to;
            seen_to = 1'b0;
            repeat (20) begin
                @(negedge Clk);
                if (err_timeout !== 1'b0) seen_to = 1'b1;
            end
            checks++;
            if ({seen_to, busy, res_valid} !== 3'b010) begin
                failures++;
                $display("FAIL nowd_hold got=%b exp=010", {seen_to, busy, res_valid});
            end
        end
`endif
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        checks++;
        if ({busy, res_valid, feat_ready, nn_start} !== 4'b0010) begin
            failures++;
            $display("FAIL rstw_ctrl got=%b exp=0010", {busy, res_valid, feat_ready, nn_start});
        end
        checks++;
        if (nn_x !== '0) begin
            failures++;
            $display("FAIL rstw_nn_x got=%h exp=0", nn_x);
        end
    endtask

`ifdef NN_WATCHDOG_EN
    task automatic test_watchdog();
        send_frame(N_FEAT, N_FEAT - 1, 32'h8888_0000);
        repeat (8) @(negedge Clk);
        checks++;
        if ({err_timeout, busy} !== 2'b01) begin
            failures++;
            $display("FAIL wd_before got=%b exp=01", {err_timeout, busy});
        end
        @(negedge Clk);
        checks++;
        if ({err_timeout, busy, res_valid, feat_ready} !== 4'b1001) begin
            failures++;
            $display("FAIL wd_expire got=%b exp=1001", {err_timeout, busy, res_valid, feat_ready});
        end
        @(negedge Clk);
        checks++;
        if ({err_timeout, res_valid} !== 2'b00) begin
            failures++;
            $display("FAIL wd_pulse got=%b exp=00", {err_timeout, res_valid});
        end
        // nn_done on the expiry cycle wins.
        send_frame(N_FEAT, N_FEAT - 1, 32'h9999_0000);
        finish_inference(32'h3F80_0000, 32'h4000_0000, 8);
        checks++;
        if ({err_timeout, res_valid, res_class, res_score} !== {3'b011, 32'h4000_0000}) begin
            failures++;
            $display("FAIL wd_done_wins got=%b%b/%0d/%h exp=01/1/40000000",
                     err_timeout, res_valid, res_class, res_score);
        end
        accept_result();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        Reset_n    = 1'b0;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        nn_done    = 1'b0;
        nn_o       = '0;
        res_ready  = 1'b0;
        test_reset();
        test_basic();
        test_compare();
        test_tie_hold();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef NN_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
